serial_subtractor_ctrl: RTL

Bit-serial multi-bit subtractor controller that computes `op_a - op_b - borrow_in` by sequencing a single instantiated `fullsubtractor` cell over WIDTH clock cycles, LSB first. It owns the operand shift registers, the borrow feedback flop, the bit counter and the start/done handshake. It sits between a requester that needs occasional wide subtractions and the one-bit subtractor datapath, trading latency for area.

---
 rtl/serial_subtractor_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor controller: op_a - op_b - borrow_in over WIDTH cycles, LSB first.
// Optional SERIAL_SUB_SAT_EN clamps diff to zero on underflow.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_brw;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_next;

  fullsubtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_brw),
    .diff (w_d),
    .bout (w_bo)
  );

  // Result register after this cycle's bit lands in the MSB.
  assign w_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_brw   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_brw   <= borrow_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_res <= w_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_brw <= w_bo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_bout  <= w_bo;
`ifdef SERIAL_SUB_SAT_EN
            r_diff  <= w_bo ? '0 : w_next;
`else
            r_diff  <= w_next;
`endif
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule
